// File: rtl/hog_svm_pkg.sv
// Shared definitions for the HOG/SVM result path: default window geometry
// and the frame state encoding used by the result buffer.
package hog_svm_pkg;

    localparam int HOG_SW_W  = 11;
    localparam int HOG_N_SW  = 1200;
    localparam int HOG_DEPTH = 16;
    localparam int HOG_CNT_W = 11;

    typedef enum logic {
        RUN  = 1'b0,
        WRAP = 1'b1
    } frame_st_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg, wr_ptr_next;
    logic [AW:0]      rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      rd_ptr_inc;
    logic [WIDTH-1:0] head_reg, head_next;
    logic             do_push, do_pop;

    assign empty      = (wr_ptr_reg == rd_ptr_reg);
    assign full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop     = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign do_push    = push && (!full || do_pop);
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;
    assign head       = head_reg;

    always_comb begin
        wr_ptr_next = do_push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next = do_pop  ? rd_ptr_inc        : rd_ptr_reg;
        head_next   = head_reg;
        if (do_pop) begin
            // The next head is either already in memory or is the word
            // being written right now (when only one entry remained).
            if (rd_ptr_inc != wr_ptr_reg) begin
                head_next = mem[rd_ptr_inc[AW-1:0]];
            end else if (do_push) begin
                head_next = push_data;
            end
        end else if (empty && do_push) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            head_reg   <= head_next;
        end
    end

endmodule

// File: rtl/sw_result_buf.sv
// Queues positive SVM window indices for a slow consumer and tracks frame
// boundaries. Optional frame statistics are built with SW_RESULT_BUF_STATS_EN.
module sw_result_buf
    import hog_svm_pkg::*;
#(
    parameter int SW_W  = HOG_SW_W,
    parameter int N_SW  = HOG_N_SW,
    parameter int DEPTH = HOG_DEPTH,
    parameter int CNT_W = HOG_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             is_person,
    input  logic [SW_W-1:0]  sw_id,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [SW_W-1:0]  o_sw_id,
    output logic             overflow,
    output logic             seq_err,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_hits
);

    localparam logic [SW_W-1:0] LAST_ID = SW_W'(N_SW - 1);

    logic            fifo_full, fifo_empty;
    logic            push_req, drop, mismatch, frame_end;
    logic [SW_W-1:0] exp_id_reg, exp_id_next;
    logic            overflow_reg, overflow_next;
    logic            seq_err_reg, seq_err_next;

    sync_fifo #(
        .WIDTH (SW_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (sw_id),
        .pop       (o_ready),
        .head      (o_sw_id),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign push_req  = i_valid && is_person;
    // When full the FIFO is non-empty, so o_ready alone means a pop occurs.
    assign drop      = push_req && fifo_full && !o_ready;
    assign mismatch  = i_valid && (sw_id != exp_id_reg);
    assign frame_end = i_valid && (exp_id_reg == LAST_ID);
    assign o_valid   = !fifo_empty;
    assign overflow  = overflow_reg;
    assign seq_err   = seq_err_reg;

    always_comb begin
        exp_id_next   = exp_id_reg;
        overflow_next = overflow_reg | drop;
        seq_err_next  = seq_err_reg | mismatch;
        if (i_valid) begin
            exp_id_next = frame_end ? '0 : exp_id_reg + 1'b1;
        end
        // Stickies restart at the frame boundary but keep an event raised
        // by the closing window itself.
        if (frame_end) begin
            overflow_next = drop;
            seq_err_next  = mismatch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_id_reg   <= '0;
            overflow_reg <= 1'b0;
            seq_err_reg  <= 1'b0;
        end else begin
            exp_id_reg   <= exp_id_next;
            overflow_reg <= overflow_next;
            seq_err_reg  <= seq_err_next;
        end
    end

`ifdef SW_RESULT_BUF_STATS_EN
    localparam logic [CNT_W-1:0] HIT_MAX = {CNT_W{1'b1}};

    frame_st_t        st_reg, st_next;
    logic [CNT_W-1:0] hit_cnt_reg, hit_cnt_next;
    logic [CNT_W-1:0] frame_hits_reg, frame_hits_next;
    logic [CNT_W-1:0] hit_total;

    assign hit_total  = (push_req && hit_cnt_reg != HIT_MAX) ? hit_cnt_reg + 1'b1
                                                             : hit_cnt_reg;
    assign frame_done = (st_reg == WRAP);
    assign frame_hits = frame_hits_reg;

    always_comb begin
        st_next         = st_reg;
        hit_cnt_next    = hit_total;
        frame_hits_next = frame_hits_reg;
        case (st_reg)
            RUN:     st_next = frame_end ? WRAP : RUN;
            WRAP:    st_next = RUN;
            default: st_next = RUN;
        endcase
        if (frame_end) begin
            hit_cnt_next    = '0;
            frame_hits_next = hit_total;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_reg         <= RUN;
            hit_cnt_reg    <= '0;
            frame_hits_reg <= '0;
        end else begin
            st_reg         <= st_next;
            hit_cnt_reg    <= hit_cnt_next;
            frame_hits_reg <= frame_hits_next;
        end
    end
`else
    assign frame_done = 1'b0;
    assign frame_hits = '0;
`endif

endmodule

// File: tb/tb_sw_result_buf.sv
// Scoreboard bench for sw_result_buf: a driver models the frame rules and
// queues expected indices, an independent monitor checks every pop.
module tb_sw_result_buf;

    localparam int SW_W  = 11;
    localparam int N_SW  = 1200;
    localparam int DEPTH = 16;
    localparam int CNT_W = 11;
`ifdef SW_RESULT_BUF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_valid = 1'b0;
    logic             is_person = 1'b0;
    logic [SW_W-1:0]  sw_id = '0;
    logic             o_valid;
    logic             o_ready = 1'b0;
    logic [SW_W-1:0]  o_sw_id;
    logic             overflow;
    logic             seq_err;
    logic             frame_done;
    logic [CNT_W-1:0] frame_hits;

    always #5 clk = ~clk;

    sw_result_buf #(
        .SW_W  (SW_W),
        .N_SW  (N_SW),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .is_person  (is_person),
        .sw_id      (sw_id),
        .o_valid    (o_valid),
        .o_ready    (o_ready),
        .o_sw_id    (o_sw_id),
        .overflow   (overflow),
        .seq_err    (seq_err),
        .frame_done (frame_done),
        .frame_hits (frame_hits)
    );

    int checks = 0;
    int errors = 0;
    int sb_q[$];

    // Reference model of the frame rules
    int m_cnt = 0, m_exp = 0, m_hits = 0, m_fhits = 0;
    bit m_ovf = 0, m_seq = 0, m_done = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_outputs();
        chk("o_valid", int'(o_valid), int'(m_cnt > 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("seq_err", int'(seq_err), int'(m_seq));
        chk("frame_done", int'(frame_done), STATS ? int'(m_done) : 0);
        chk("frame_hits", int'(frame_hits), STATS ? m_fhits : 0);
    endtask

    task automatic step(input bit v, input bit p, input int id, input bit r);
        bit pop, acc, drop;
        rst       = 1'b0;
        i_valid   = v;
        is_person = p;
        sw_id     = SW_W'(id);
        o_ready   = r;
        pop  = (m_cnt > 0) && r;
        acc  = v && p && ((m_cnt < DEPTH) || pop);
        drop = v && p && !acc;
        if (acc) sb_q.push_back(id);
        m_cnt  = m_cnt + int'(acc) - int'(pop);
        m_done = 1'b0;
        if (v) begin
            if (p && m_hits < 2**CNT_W - 1) m_hits++;
            if (m_exp == N_SW - 1) begin
                m_ovf   = drop;
                m_seq   = (id != m_exp);
                m_fhits = m_hits;
                m_hits  = 0;
                m_done  = 1'b1;
                m_exp   = 0;
            end else begin
                m_ovf = m_ovf | drop;
                m_seq = m_seq | (id != m_exp);
                m_exp++;
            end
        end
        @(posedge clk); #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; i_valid = 1'b0; is_person = 1'b0; o_ready = 1'b0;
        sb_q.delete();
        m_cnt = 0; m_exp = 0; m_hits = 0; m_fhits = 0;
        m_ovf = 0; m_seq = 0; m_done = 0;
        @(posedge clk); #1;
        check_outputs();
        chk("reset_o_sw_id", int'(o_sw_id), 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb_q.size() > 0 && n < budget) begin
            step(1'b0, 1'b0, 0, 1'b1);
            n++;
        end
        step(1'b0, 1'b0, 0, 1'b1);
        chk("drain_left", sb_q.size(), 0);
    endtask

    // Monitor: every handshake pops the scoreboard; held heads must not move.
    bit              hold_v = 1'b0;
    logic [SW_W-1:0] hold_id = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (hold_v) begin
                chk("hold_valid", int'(o_valid), 1);
                chk("hold_id", int'(o_sw_id), int'(hold_id));
            end
            if (o_valid && o_ready && !rst) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pop", int'(o_sw_id), -1);
                end else begin
                    chk("pop_id", int'(o_sw_id), sb_q.pop_front());
                end
            end
            hold_v  = o_valid && !o_ready && !rst;
            hold_id = o_sw_id;
        end
    end

    initial begin
        int k;
        int id;
        bit v;

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Frame 1: positives at 5, 6, 700 with a ready consumer
        for (int i = 0; i < N_SW; i++)
            step(1'b1, (i == 5) || (i == 6) || (i == 700), i, 1'b1);
        repeat (3) step(1'b0, 1'b0, 0, 1'b1);
        chk("f1_queue_empty", sb_q.size(), 0);

        // Frame 2: stalled consumer, 20 consecutive positives
        for (int i = 0; i < N_SW; i++)
            step(1'b1, i < 20, i, 1'b0);
        drain(40);

        // Frame 3: fill, push+pop while full, overflow, then random traffic
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, i, 1'b0);
        step(1'b1, 1'b1, 16, 1'b1);
        step(1'b1, 1'b0, 17, 1'b0);
        step(1'b1, 1'b1, 18, 1'b0);
        for (int i = 19; i < N_SW; i++)
            step(1'b1, $urandom_range(0, 7) == 0, i, $urandom_range(0, 1) == 1);
        drain(40);

        // Frame 4: window 7 replaced by 8, random gaps and random readiness
        k = 0;
        while (k < N_SW) begin
            v  = $urandom_range(0, 3) != 0;
            id = (k == 7) ? 8 : k;
            step(v, $urandom_range(0, 5) == 0, id, $urandom_range(0, 2) != 0);
            if (v) k++;
        end
        drain(40);

        // Frame 5: reset with five entries queued, mid-frame
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i, 1'b0);
        for (int i = 5; i < 100; i++) step(1'b1, 1'b0, i, 1'b0);
        do_reset();

        // Frame 6: fresh frame from window 0 with random traffic
        for (int i = 0; i < N_SW; i++)
            step(1'b1, $urandom_range(0, 3) == 0, i, $urandom_range(0, 3) != 0);
        drain(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
